// File: rtl/counter_4bit_down_pkg.sv
// Shared constants and FSM state encoding for the cascadable 4-bit down counter.
package counter_4bit_down_pkg;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_TERM = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_4bit_down.sv
// Cascadable 4-bit down counter with parallel load, free-run wrap or one-shot expiry.
module counter_4bit_down
  import counter_4bit_down_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] D,
  input  logic       mode,
  output logic       Qa,
  output logic       Qb,
  output logic       Qc,
  output logic       Qd,
  output logic       Rb,
  output logic       done
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             count_zero;

  assign count_zero = (count == '0);

  // Borrow is combinational so the next stage sees it in the same cycle.
  assign Rb = (state == RUN) & en & count_zero;

  assign Qa = count[0];
  assign Qb = count[1];
  assign Qc = count[2];
  assign Qd = count[3];

  // Next-state and next-count: load beats enable; IDLE and DONE ignore en.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (ld) begin
      state_nxt = RUN;
      count_nxt = D;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (!count_zero) begin
              count_nxt = count - CNT_W'(1);
            end else if (!mode) begin
              count_nxt = CNT_TERM;
            end else begin
              state_nxt = DONE;
              count_nxt = '0;
            end
          end
        end
        DONE: begin
          count_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= (state_nxt == DONE);
    end
  end

endmodule
